// File: rtl/reg_bus_pkg.sv
// rtl/reg_bus_pkg.sv - shared FSM states, default widths and index helper for the register-bus arbiter
package reg_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    LOAD  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_DW     = 8;
  localparam int DEF_REG_AW = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin picker: first set request at or above the pointer, wrapping
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_gnt_oh,
  output logic [IW-1:0]      o_idx,
  output logic               o_valid
);

  int          w_pos;
  logic [IW-1:0] w_sel;

  always_comb begin
    o_gnt_oh = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    w_pos    = 0;
    w_sel    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_pos = int'(i_ptr) + k;
      if (w_pos >= NUM_REQ) w_pos = w_pos - NUM_REQ;
      w_sel = IW'(w_pos);
      if (!o_valid && i_req[w_sel]) begin
        o_valid         = 1'b1;
        o_idx           = w_sel;
        o_gnt_oh[w_sel] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_bus_arbiter.sv
// rtl/reg_bus_arbiter.sv - round-robin arbiter for the shared register-load bus (IDLE/GRANT/LOAD/DONE)
// Optional write protection with per-register mask and err pulse: define REG_WRITE_PROTECT_EN.
module reg_bus_arbiter
  import reg_bus_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int NUM_REG = 4,
  parameter int DW      = DEF_DW,
  parameter int REG_AW  = DEF_REG_AW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*REG_AW-1:0] req_dst,
  input  logic [NUM_REQ*DW-1:0]     req_data,
`ifdef REG_WRITE_PROTECT_EN
  input  logic [NUM_REG-1:0]        wp_mask,
  output logic [NUM_REQ-1:0]        err,
`endif
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [DW-1:0]             bus_d,
  output logic [NUM_REG-1:0]        reg_en,
  output logic                      busy
);

  localparam int RIW = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [RIW-1:0]      r_ptr;
  logic [RIW-1:0]      r_win_idx;
  logic [NUM_REQ-1:0]  r_win_oh;
  logic [REG_AW-1:0]   r_dst;
  logic                r_wp;
  logic [DW-1:0]       r_bus_d;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [NUM_REQ-1:0]  r_done;
  logic [NUM_REG-1:0]  r_reg_en;

  logic [NUM_REQ-1:0]  w_pick_oh;
  logic [RIW-1:0]      w_pick_idx;
  logic                w_pick_valid;
  logic [REG_AW-1:0]   w_pick_dst;
  logic [DW-1:0]       w_pick_data;
  logic                w_pick_wp;
  logic [NUM_REG-1:0]  w_en_oh;
  logic [NUM_REQ-1:0]  w_gnt_nxt;
  logic [NUM_REQ-1:0]  w_done_nxt;
  logic [NUM_REG-1:0]  w_reg_en_nxt;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IW      (RIW)
  ) u_rr_picker (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_gnt_oh (w_pick_oh),
    .o_idx    (w_pick_idx),
    .o_valid  (w_pick_valid)
  );

  assign w_pick_dst  = req_dst[w_pick_idx*REG_AW +: REG_AW];
  assign w_pick_data = req_data[w_pick_idx*DW +: DW];

`ifdef REG_WRITE_PROTECT_EN
  always_comb begin
    w_pick_wp = 1'b0;
    for (int k = 0; k < NUM_REG; k++)
      if (w_pick_dst == REG_AW'(k)) w_pick_wp = wp_mask[k];
  end
`else
  assign w_pick_wp = 1'b0;
`endif

  // Destinations beyond NUM_REG never match, so out-of-range transfers decode to all-zero.
  always_comb begin
    w_en_oh = '0;
    for (int k = 0; k < NUM_REG; k++)
      if (r_dst == REG_AW'(k)) w_en_oh[k] = ~r_wp;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_pick_valid) w_state_nxt = GRANT;
      GRANT:   w_state_nxt = LOAD;
      LOAD:    w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are computed for the upcoming state and registered alongside it.
  always_comb begin
    w_gnt_nxt    = '0;
    w_done_nxt   = '0;
    w_reg_en_nxt = '0;
    case (w_state_nxt)
      GRANT:   w_gnt_nxt = (r_state == IDLE) ? w_pick_oh : r_win_oh;
      LOAD: begin
        w_gnt_nxt    = r_win_oh;
        w_reg_en_nxt = w_en_oh;
      end
      DONE: begin
        w_gnt_nxt  = r_win_oh;
        w_done_nxt = r_win_oh;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= '0;
      r_win_idx <= '0;
      r_win_oh  <= '0;
      r_dst     <= '0;
      r_wp      <= 1'b0;
      r_bus_d   <= '0;
      r_gnt     <= '0;
      r_done    <= '0;
      r_reg_en  <= '0;
    end else begin
      r_gnt    <= w_gnt_nxt;
      r_done   <= w_done_nxt;
      r_reg_en <= w_reg_en_nxt;
      if (r_state == IDLE && w_pick_valid) begin
        r_win_idx <= w_pick_idx;
        r_win_oh  <= w_pick_oh;
        r_dst     <= w_pick_dst;
        r_wp      <= w_pick_wp;
        r_bus_d   <= w_pick_data;
      end
      if (r_state == DONE)
        r_ptr <= (int'(r_win_idx) == NUM_REQ - 1) ? '0 : r_win_idx + 1'b1;
    end
  end

`ifdef REG_WRITE_PROTECT_EN
  logic [NUM_REQ-1:0] r_err;

  always_ff @(posedge clk) begin
    if (rst) r_err <= '0;
    else     r_err <= r_wp ? w_done_nxt : '0;
  end

  assign err = r_err;
`endif

  assign gnt    = r_gnt;
  assign done   = r_done;
  assign reg_en = r_reg_en;
  assign bus_d  = r_bus_d;
  assign busy   = (r_state != IDLE);

endmodule
